hdc_class_search: RTL

HDC_CLASS_SEARCH -- requirements
Module: hdc_class_search

---
 rtl/hdc_class_search.sv | 120 ++++++++++++
 1 files changed

// File: rtl/hdc_class_search.sv
// Nearest-class search over hypervectors: buffers a multi-frame query, streams every
// class frame past it, and reports the class with minimum Hamming distance.
module hdc_class_search #(
  parameter int unsigned DI_PARALLEL_W_BITS = 64,
  parameter int unsigned NUM_CLASSES        = 8,
  parameter int unsigned NUM_FRAMES         = 3,
  localparam int unsigned DIST_W = $clog2(NUM_FRAMES * DI_PARALLEL_W_BITS + 1),
  localparam int unsigned CID_W  = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1,
  localparam int unsigned FI_W   = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DI_PARALLEL_W_BITS-1:0] query_frame_in,
  input  logic                          query_valid,
  output logic                          query_ready,
  output logic [CID_W-1:0]              frame_id,
  output logic [FI_W-1:0]               frame_index,
  input  logic [DI_PARALLEL_W_BITS-1:0] class_vec_in,
  output logic [CID_W-1:0]              pred_class,
  output logic [DIST_W-1:0]             pred_dist,
  output logic                          result_valid,
  input  logic                          result_ready
);

  typedef enum logic [1:0] {LOAD, SEARCH, DONE} state_t;

  localparam logic [FI_W-1:0]  LAST_F = FI_W'(NUM_FRAMES - 1);
  localparam logic [CID_W-1:0] LAST_C = CID_W'(NUM_CLASSES - 1);

  state_t                        r_state;
  logic [FI_W-1:0]               r_q_cnt;
  logic [DIST_W-1:0]             r_acc;
  logic [DIST_W-1:0]             r_best_dist;
  logic [CID_W-1:0]              r_best_class;
  logic [DI_PARALLEL_W_BITS-1:0] r_buf [NUM_FRAMES];

  logic [DIST_W-1:0] w_d;
  logic [DIST_W-1:0] w_total;
  logic              w_better;

  // frame_id / frame_index double as the class and frame counters so the
  // generator's combinational reply lines up with the buffered query frame.
  assign w_d      = DIST_W'($countones(r_buf[frame_index] ^ class_vec_in));
  assign w_total  = r_acc + w_d;
  assign w_better = (w_total < r_best_dist);

  // Query buffer carries no reset; stale contents are always overwritten before use.
  always_ff @(posedge clk) begin
    if (r_state == LOAD && query_valid) begin
      r_buf[r_q_cnt] <= query_frame_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= LOAD;
      r_q_cnt      <= '0;
      r_acc        <= '0;
      r_best_dist  <= '1;
      r_best_class <= '0;
      query_ready  <= 1'b1;
      result_valid <= 1'b0;
      pred_class   <= '0;
      pred_dist    <= '0;
      frame_id     <= '0;
      frame_index  <= '0;
    end else begin
      case (r_state)
        LOAD: begin
          if (query_valid) begin
            if (r_q_cnt == LAST_F) begin
              r_q_cnt     <= '0;
              r_acc       <= '0;
              r_best_dist <= '1;
              frame_id    <= '0;
              frame_index <= '0;
              query_ready <= 1'b0;
              r_state     <= SEARCH;
            end else begin
              r_q_cnt <= r_q_cnt + FI_W'(1);
            end
          end
        end
        SEARCH: begin
          if (frame_index != LAST_F) begin
            r_acc       <= w_total;
            frame_index <= frame_index + FI_W'(1);
          end else begin
            r_acc       <= '0;
            frame_index <= '0;
            if (w_better) begin
              r_best_dist  <= w_total;
              r_best_class <= frame_id;
            end
            if (frame_id == LAST_C) begin
              frame_id     <= '0;
              result_valid <= 1'b1;
              pred_class   <= w_better ? frame_id : r_best_class;
              pred_dist    <= w_better ? w_total : r_best_dist;
              r_state      <= DONE;
            end else begin
              frame_id <= frame_id + CID_W'(1);
            end
          end
        end
        DONE: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            pred_class   <= '0;
            pred_dist    <= '0;
            query_ready  <= 1'b1;
            r_state      <= LOAD;
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end

endmodule
